// File: rtl/bullet_wave_scheduler_if.sv
// Bus between the bullet wave scheduler and its game-logic neighbours.
// The scheduler sits on the slave modport; the game top or bench drives the master modport.
interface bullet_wave_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [3:0]           state;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 collision;
  logic [NUM_SLOTS-1:0] slot_done;
  logic [NUM_SLOTS-1:0] slot_active;
  logic                 spawn_valid;
  logic [2:0]           spawn_slot;
  logic [9:0]           spawn_x;
  logic [9:0]           spawn_y;
  logic [3:0]           spawn_dir;
  logic                 clear_all;
  logic [7:0]           hit_count;
  logic                 wave_done;

  modport master (
    output state, x, y, collision, slot_done,
    input  slot_active, spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_dir,
           clear_all, hit_count, wave_done
  );

  modport slave (
    input  state, x, y, collision, slot_done,
    output slot_active, spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_dir,
           clear_all, hit_count, wave_done
  );
endinterface

// File: rtl/bullet_wave_scheduler.sv
// Runs one attack wave: spawns bullets into free slots on a frame interval, counts hits, flags completion.
// Spawn strobe and slot updates are registered one clk after the frame tick; a full pool defers the spawn.
module bullet_wave_scheduler #(
  parameter int          NUM_SLOTS      = 4,
  parameter int          ATTACK_STATE   = 1,
  parameter int          SPAWN_INTERVAL = 30,
  parameter int          WAVE_FRAMES    = 300,
  parameter int          INVULN_FRAMES  = 60,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input logic                   clk,
  input logic                   reset,
  bullet_wave_scheduler_if.slave io_bus
);
  localparam int FW = $clog2(WAVE_FRAMES + 1);
  localparam int TW = $clog2(SPAWN_INTERVAL + 1);
  localparam int IW = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(WAVE_FRAMES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_INTERVAL - 1);
  localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_cond_d, r_coll_d;
  logic [7:0]           r_lfsr;
  logic [FW-1:0]        r_frame_cnt;
  logic [TW-1:0]        r_spawn_timer;
  logic [IW-1:0]        r_invuln_cnt;
  logic [7:0]           r_hit_count;
  logic [NUM_SLOTS-1:0] r_slot_active;
  logic                 r_spawn_valid, r_clear_all;
  logic [2:0]           r_spawn_slot;
  logic [9:0]           r_spawn_x, r_spawn_y;
  logic [3:0]           r_spawn_dir;

  logic                 w_cond, w_tick, w_rise, w_attack, w_abort, w_spawn;
  logic                 w_start, w_in_play, w_wave_done, w_any_free;
  logic [2:0]           w_free_idx;
  logic [NUM_SLOTS-1:0] w_free, w_spawn_mask;
  logic [7:0]           w_lfsr_nxt;

  // Frame tick is the first clk of the last visible pixel, however long it is held.
  assign w_cond     = (io_bus.x == 10'd639) && (io_bus.y == 10'd479);
  assign w_tick     = w_cond & ~r_cond_d;
  assign w_rise     = io_bus.collision & ~r_coll_d;
  assign w_attack   = (io_bus.state == 4'(ATTACK_STATE));
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // A slot retiring this cycle is already eligible for reuse.
  assign w_free = ~r_slot_active | io_bus.slot_done;

  always_comb begin
    w_free_idx = 3'd0;
    w_any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_free_idx = 3'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_abort      = w_in_play && !w_attack;
  assign w_spawn      = (r_state == S_RUN) && w_attack && w_tick &&
                        (r_spawn_timer == TIMER_LAST) && w_any_free;
  assign w_spawn_mask = w_spawn ? (NUM_SLOTS'(1) << w_free_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_attack) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!w_attack)                               w_state_nxt = S_IDLE;
        else if (w_tick && r_frame_cnt == FRAME_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_attack)               w_state_nxt = S_IDLE;
        else if (r_slot_active == '0) w_state_nxt = S_DONE;
      end
      S_DONE:  if (!w_attack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start     = (r_state == S_IDLE) && w_attack;
    w_in_play   = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_wave_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_d      <= 1'b0;
      r_coll_d      <= 1'b0;
      r_lfsr        <= LFSR_SEED;
      r_frame_cnt   <= '0;
      r_spawn_timer <= '0;
      r_invuln_cnt  <= '0;
      r_hit_count   <= 8'd0;
      r_slot_active <= '0;
      r_spawn_valid <= 1'b0;
      r_clear_all   <= 1'b0;
      r_spawn_slot  <= 3'd0;
      r_spawn_x     <= 10'd0;
      r_spawn_y     <= 10'd0;
      r_spawn_dir   <= 4'd0;
    end else begin
      r_cond_d      <= w_cond;
      r_coll_d      <= io_bus.collision;
      r_spawn_valid <= w_spawn;
      r_clear_all   <= w_abort;
      if (w_tick) r_lfsr <= w_lfsr_nxt;

      if (w_abort) r_slot_active <= '0;
      else         r_slot_active <= (r_slot_active & ~io_bus.slot_done) | w_spawn_mask;

      if (w_spawn) begin
        r_spawn_slot <= w_free_idx;
        r_spawn_x    <= 10'd128 + {2'b00, r_lfsr};
        r_spawn_y    <= 10'd110 + {3'b000, r_lfsr[3:0], 3'b000};
        r_spawn_dir  <= {(r_lfsr[1] ? 2'd2 : 2'd1), (r_lfsr[0] ? 2'd2 : 2'd1)};
      end

      if (w_start) begin
        r_frame_cnt   <= '0;
        r_spawn_timer <= '0;
        r_invuln_cnt  <= '0;
        r_hit_count   <= 8'd0;
      end else begin
        if (r_state == S_RUN && w_tick) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
          if (w_spawn)                         r_spawn_timer <= '0;
          else if (r_spawn_timer != TIMER_LAST) r_spawn_timer <= r_spawn_timer + 1'b1;
        end
        // Only an edge of collision counts, and only once immunity has run out.
        if (w_in_play && w_rise && r_invuln_cnt == '0) begin
          if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
          r_invuln_cnt <= INV_LOAD;
        end else if (w_tick && r_invuln_cnt != '0) begin
          r_invuln_cnt <= r_invuln_cnt - 1'b1;
        end
      end
    end
  end

  assign io_bus.slot_active = r_slot_active;
  assign io_bus.spawn_valid = r_spawn_valid;
  assign io_bus.spawn_slot  = r_spawn_slot;
  assign io_bus.spawn_x     = r_spawn_x;
  assign io_bus.spawn_y     = r_spawn_y;
  assign io_bus.spawn_dir   = r_spawn_dir;
  assign io_bus.clear_all   = r_clear_all;
  assign io_bus.hit_count   = r_hit_count;
  assign io_bus.wave_done   = w_wave_done;
endmodule

// File: doc/bullet_wave_scheduler.md
Name: bullet_wave_scheduler

Overview:
Sequences one attack wave of bouncing bullet sprites during the fight state. Owns a pool of NUM_SLOTS bullet slots and spawns bullets into free slots at a fixed frame interval, with LFSR-chosen start position and direction. Retires slots as the bullet sprites report done, counts player hits with invulnerability frames, and flags wave completion to the top-level game state machine.

Parameters:
NUM_SLOTS, 4, number of bullet sprite instances managed (1..8)
ATTACK_STATE, 1, value of state[3:0] that enables the wave
SPAWN_INTERVAL, 30, frames between spawns (>=1)
WAVE_FRAMES, 300, frames of spawning before drain
INVULN_FRAMES, 60, frames of hit immunity after a counted hit
LFSR_SEED, 8'hA5, non-zero reset/reload value of the 8-bit LFSR

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
state  in  4  game state from top-level FSM
x  in  10  current pixel column from vga sync
y  in  10  current pixel row from vga sync
collision  in  1  heart/bullet overlap, level signal
slot_done  in  NUM_SLOTS  per-slot pulse: bullet expired/consumed
slot_active  out  NUM_SLOTS  slot currently owned by a live bullet
spawn_valid  out  1  one-cycle spawn strobe
spawn_slot  out  3  slot index for spawn_valid
spawn_x  out  10  initial bullet x
spawn_y  out  10  initial bullet y
spawn_dir  out  4  {y_dir[1:0],x_dir[1:0]}; 1=negative, 2=positive, never 0 or 3
clear_all  out  1  one-cycle strobe: all bullets must reset
hit_count  out  8  counted hits this wave, saturating
wave_done  out  1  high while in DONE

Behaviour:
- Reset: FSM=IDLE; slot_active=0, spawn_valid=0, spawn_slot=0, spawn_x=0, spawn_y=0, spawn_dir=0, clear_all=0, hit_count=0, wave_done=0; lfsr=LFSR_SEED; all counters 0.
- frame_tick: one clk pulse on rising edge of (x==639 && y==479), i.e. cond && !cond_d; a pixel held for several clks yields exactly one tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every frame_tick in all states; never reaches 0.
- FSM states IDLE, RUN, DRAIN, DONE.
- IDLE: on state==ATTACK_STATE -> RUN next clk; clear frame_cnt, spawn_timer, invuln_cnt, hit_count.
- RUN: each frame_tick: frame_cnt+1; spawn_timer+1, saturating at SPAWN_INTERVAL-1. Spawn fires when spawn_timer==SPAWN_INTERVAL-1 at a frame_tick and a free slot exists; then spawn_timer resets to 0.
- If no slot is free, the spawn is deferred: timer stays saturated and spawn fires on the first later frame_tick with a free slot.
- Free mask = ~slot_active | slot_done. A slot released this cycle may be re-spawned this cycle. Lowest-index free slot wins.
- Spawn (registered, 1 clk after the frame_tick): spawn_valid=1 for exactly 1 clk; slot_active[spawn_slot] set; spawn_x=128+lfsr[7:0] (128..383); spawn_y=110+{lfsr[3:0],3'b0} (110..230); spawn_dir x=lfsr[0]?2:1, y=lfsr[1]?2:1.
- RUN exit: when frame_cnt reaches WAVE_FRAMES-1 on a frame_tick -> DRAIN. A spawn due on that same tick still occurs.
- DRAIN: no spawns; slot_done clears its slot bits; when slot_active==0 -> DONE next clk.
- DONE: wave_done=1; when state!=ATTACK_STATE -> IDLE, wave_done=0.
- Abort: state!=ATTACK_STATE in RUN or DRAIN -> IDLE; slot_active=0 and clear_all=1 for 1 clk. Pending spawns are cancelled. hit_count is held until the next wave entry.
- Hits, RUN/DRAIN only: collision rising edge with invuln_cnt==0 -> hit_count+1, saturating at 255; invuln_cnt=INVULN_FRAMES.
- invuln_cnt decrements on frame_tick while non-zero. collision held high does not re-count after invulnerability expires; a new rising edge is required.
- slot_done on an inactive slot: ignored.
- Reset mid-wave: returns to reset values next clk; clear_all is not asserted.

Test Plan:
1. Reset, state=1, drive 31 frames of x/y sweep -> RUN, one spawn_valid at frame 30 with spawn_slot=0, slot_active=4'b0001; spawn_x in 128..383; spawn_dir fields in {1,2}.
2. Hold slot_done=0 for 150 frames -> spawns at frames 30/60/90/120 to slots 0..3. Frame 150: no spawn. Pulse slot_done[2] at frame 170 -> slot 2 spawned at frame 171.
3. slot_done[0] and spawn due on the same clk with all slots full -> slot 0 re-spawned; slot_active stays 4'b1111; exactly one spawn_valid.
4. Collision pulsed at frames 10, 40, 80 -> hit_count=2; the frame-40 pulse is ignored under invuln. Collision held high 200 frames -> hit_count=1.
5. After 300 frames -> DRAIN, no spawns. Retire all slots -> wave_done=1. Set state=2 -> wave_done=0, IDLE.
6. state 1->0 at frame 100 -> clear_all 1-clk pulse, slot_active=0, IDLE. Assert reset mid-RUN -> all outputs at reset values next clk.
